universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/shift_reg_pkg.sv | 20 ++
 rtl/sat_counter.sv | 48 ++++
 rtl/universal_shift_register.sv | 88 ++++++++
 tb/tb_universal_shift_register.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family.
// Contents:
//   shift_mode_e : operation select (hold, shift-left, shift-right, load)
//   sat_next     : next value of a counter that saturates at a limit
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_e;

  // Next value of a counter that saturates at lim.
  // The count is handled as a 32-bit int so that one function serves every counter width.
  function automatic int sat_next(input int cur, input int lim);
    return (cur >= lim) ? lim : cur + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, forces cnt to 0
//   clr    : synchronous clear, has priority over inc
//   inc    : count up by one, stops at MAX
//   cnt    : current count (registered)
//   at_max : high while cnt == MAX (decode of registered state)
module sat_counter
  import shift_reg_pkg::*;
#(
  parameter int MAX   = 8,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_next(int'(cnt_q), MAX));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift-left, shift-right and parallel load,
// with a saturating count of the shifts made since the last load or reset.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset (q, shift_cnt and done go to 0)
//   en        : clock enable; when low, everything holds and mode is ignored
//   mode      : 00 hold, 01 shift-left, 10 shift-right, 11 parallel load
//   sin_l     : serial input, enters bit 0 on a shift-left
//   sin_r     : serial input, enters bit WIDTH-1 on a shift-right
//   pdata     : parallel load data
//   q         : register contents
//   sout_l    : q[WIDTH-1]
//   sout_r    : q[0]
//   shift_cnt : number of shifts since the last load or reset, saturating at WIDTH
//   done      : high when shift_cnt == WIDTH
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  if (WIDTH < 2) begin : g_width_check
    $error("universal_shift_register: WIDTH must be at least 2");
  end

  shift_mode_e      mode_e;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             cnt_clr;
  logic             cnt_inc;

  assign mode_e = shift_mode_e'(mode);

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_e)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_LOAD: q_d = pdata;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // The shift count does not care about direction: both shift modes increment it.
  assign cnt_clr = en && (mode_e == MODE_LOAD);
  assign cnt_inc = en && ((mode_e == MODE_SHL) || (mode_e == MODE_SHR));

  sat_counter #(
    .MAX  (WIDTH),
    .CNT_W(CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (shift_cnt),
    .at_max(done)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register. A WIDTH=4 and a WIDTH=8 instance are
// driven with the same stimulus and checked against an integer reference model.
module tb_universal_shift_register;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] pdata8;
  logic [3:0] pdata4;

  logic [3:0] q4;
  logic       soutl4, soutr4, done4;
  logic [2:0] cnt4;
  logic [7:0] q8;
  logic       soutl8, soutr8, done8;
  logic [3:0] cnt8;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  int m_q4, m_c4, m_q8, m_c8;

  universal_shift_register #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata4),
    .q(q4), .sout_l(soutl4), .sout_r(soutr4),
    .shift_cnt(cnt4), .done(done4)
  );

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata8),
    .q(q8), .sout_l(soutl8), .sout_r(soutr8),
    .shift_cnt(cnt8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One enabled/disabled clock of the reference: arithmetic on integers.
  task automatic model_step(input int w, input bit e, input int md, input bit sl,
                            input bit sr, input int pd, inout int mq, inout int mc);
    int full;
    full = 1 << w;
    if (!e) return;
    case (md)
      1: begin mq = (mq * 2 + sl) % full;            mc = (mc < w) ? mc + 1 : w; end
      2: begin mq = mq / 2 + (sr ? (full / 2) : 0);  mc = (mc < w) ? mc + 1 : w; end
      3: begin mq = pd % full;                       mc = 0;                     end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_q4 = 0; m_c4 = 0; m_q8 = 0; m_c8 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q4"},    32'(q4),     32'(m_q4));
    chk({tag, "_cnt4"},  32'(cnt4),   32'(m_c4));
    chk({tag, "_done4"}, 32'(done4),  32'(m_c4 == 4));
    chk({tag, "_soutl4"},32'(soutl4), 32'((m_q4 >> 3) & 1));
    chk({tag, "_soutr4"},32'(soutr4), 32'(m_q4 & 1));
    chk({tag, "_q8"},    32'(q8),     32'(m_q8));
    chk({tag, "_cnt8"},  32'(cnt8),   32'(m_c8));
    chk({tag, "_done8"}, 32'(done8),  32'(m_c8 == 8));
    chk({tag, "_soutl8"},32'(soutl8), 32'((m_q8 >> 7) & 1));
    chk({tag, "_soutr8"},32'(soutr8), 32'(m_q8 & 1));
  endtask

  // Drive inputs (called just after an edge), clock once, then check.
  task automatic cyc(input string tag, input bit e, input logic [1:0] md,
                     input bit sl, input bit sr, input logic [7:0] pd);
    en = e; mode = md; sin_l = sl; sin_r = sr; pdata8 = pd; pdata4 = pd[3:0];
    @(posedge clk);
    model_step(4, e, int'(md), sl, sr, int'(pd), m_q4, m_c4);
    model_step(8, e, int'(md), sl, sr, int'(pd), m_q8, m_c8);
    #1;
    check_all(tag);
  endtask

  // Reset pulse between edges while a shift is set up; the inputs are
  // pushed to a load of all-ones across the next edge to show they are ignored.
  task automatic reset_pulse(input string tag);
    en = 1'b1; mode = 2'b01; sin_l = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    mode = 2'b11; pdata8 = 8'hFF; pdata4 = 4'hF;
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; sin_l = 1'b0; sin_r = 1'b0;
    pdata8 = 8'h00; pdata4 = 4'h0;
    model_reset();
    #3;
    check_all("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // load 1010
    cyc("load1010", 1, 2'b11, 0, 0, 8'h3A);
    chk("load1010_exact", 32'(q4), 32'hA);

    // clear, then shift-left 1,0,1,1
    cyc("clr", 1, 2'b11, 0, 0, 8'h00);
    cyc("shl_a", 1, 2'b01, 1, 0, 8'h00);
    cyc("shl_b", 1, 2'b01, 0, 0, 8'h00);
    cyc("shl_c", 1, 2'b01, 1, 0, 8'h00);
    cyc("shl_d", 1, 2'b01, 1, 0, 8'h00);
    chk("shl4_q",     32'(q4),     32'hB);
    chk("shl4_done",  32'(done4),  32'h1);
    chk("shl4_soutl", 32'(soutl4), 32'h1);

    // 1000 shifted right three times with zeros
    cyc("ld1000", 1, 2'b11, 0, 0, 8'h08);
    for (int i = 0; i < 3; i++) cyc("shr", 1, 2'b10, 0, 0, 8'h00);
    chk("shr3_q",     32'(q4),     32'h1);
    chk("shr3_soutr", 32'(soutr4), 32'h1);
    chk("shr3_cnt",   32'(cnt4),   32'h3);

    // disabled: mode toggled, nothing moves
    for (int i = 0; i < 5; i++) cyc("en0", 0, (i % 2 == 0) ? 2'b01 : 2'b11, 1, 1, 8'hFF);
    chk("en0_q",   32'(q4),   32'h1);
    chk("en0_cnt", 32'(cnt4), 32'h3);

    // saturation at 8, direction change keeps counting, then load clears
    cyc("ld8", 1, 2'b11, 0, 0, 8'hA5);
    for (int i = 0; i < 10; i++)
      cyc("sat", 1, (i == 4) ? 2'b10 : 2'b01, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00);
    chk("sat_cnt8",  32'(cnt8),  32'h8);
    chk("sat_done8", 32'(done8), 32'h1);
    cyc("ld_after_sat", 1, 2'b11, 0, 0, 8'h5C);
    chk("ld_cnt8",  32'(cnt8),  32'h0);
    chk("ld_done8", 32'(done8), 32'h0);

    // mid-shift asynchronous reset
    cyc("pre_rst", 1, 2'b01, 1, 0, 8'h00);
    cyc("pre_rst", 1, 2'b01, 1, 0, 8'h00);
    reset_pulse("rst_mid");
    chk("rst_mid_q8", 32'(q8), 32'h0);
    cyc("post_rst", 1, 2'b11, 0, 0, 8'hC3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        cyc("rnd", ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
